// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared constants for the two-port memory arbiter.
//                Defines the mmu access-width codes, the arbiter state
//                encodings, and the alignment-check helper used at grant.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // mmu access-width codes; 2'b11 is undefined and always rejected
    localparam logic [1:0] MMU_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] MMU_WIDTH_HALF = 2'b01;
    localparam logic [1:0] MMU_WIDTH_WORD = 2'b10;

    // Arbiter state encodings
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_DONE = 2'd2;

    // True when the access cannot be issued: a word that is not 4-byte
    // aligned, a half that is not 2-byte aligned, or an undefined width.
    function automatic logic is_misaligned(input logic [1:0] width,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (width)
            MMU_WIDTH_BYTE: bad = 1'b0;
            MMU_WIDTH_HALF: bad = addr_lo[0];
            MMU_WIDTH_WORD: bad = (addr_lo != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one mmu between the instruction-fetch port (I) and
//                the load/store port (D). One access in flight at a time;
//                misaligned accesses are rejected without touching the mmu
//                and every mmu access is bounded by TIMEOUT_CYCLES.
//  Ports       : clk, reset_n (async, active low)
//                i_req/i_addr -> i_done/i_rdata/i_err   instruction port
//                d_req/d_we/d_signed/d_width/d_addr/d_wdata
//                             -> d_done/d_rdata/d_err   data port
//                mmu_* outputs drive the mmu; mmu_data_out/mmu_ready return
//                busy : high whenever the arbiter is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_signed,
    input  logic [1:0]  d_width,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mmu_write_enable,
    output logic        mmu_read_enable,
    output logic        mmu_signed_read,
    output logic [1:0]  mmu_data_width,
    output logic [31:0] mmu_address,
    output logic [31:0] mmu_data_in,
    input  logic [31:0] mmu_data_out,
    input  logic        mmu_ready,
    output logic        busy
);

    localparam int               CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_last_d;
    logic             r_owner_d;
    logic [CNT_W-1:0] r_count;

    // Arbitration: a lone request wins; on a tie D wins unless D had the
    // previous grant. The I port is always a plain unsigned word read.
    logic        w_any_req;
    logic        w_grant_d;
    logic [31:0] w_g_addr;
    logic [1:0]  w_g_width;
    logic        w_g_signed;
    logic        w_g_we;
    logic [31:0] w_g_wdata;
    logic        w_g_misaligned;

    assign w_any_req      = i_req | d_req;
    assign w_grant_d      = d_req & (~i_req | ~r_last_d);
    assign w_g_addr       = w_grant_d ? d_addr : i_addr;
    assign w_g_width      = w_grant_d ? d_width : MMU_WIDTH_WORD;
    assign w_g_signed     = w_grant_d & d_signed;
    assign w_g_we         = w_grant_d & d_we;
    assign w_g_wdata      = w_grant_d ? d_wdata : 32'd0;
    assign w_g_misaligned = is_misaligned(w_g_width, w_g_addr[1:0]);

    // Completion of the current access: either rejected at grant, answered
    // by the mmu, or timed out. mmu_ready wins over a same-cycle timeout.
    logic        w_finish;
    logic        w_fin_owner_d;
    logic        w_fin_err;
    logic [31:0] w_fin_rdata;

    always_comb begin
        w_finish      = 1'b0;
        w_fin_owner_d = r_owner_d;
        w_fin_err     = 1'b0;
        w_fin_rdata   = 32'd0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req && w_g_misaligned) begin
                    w_finish      = 1'b1;
                    w_fin_owner_d = w_grant_d;
                    w_fin_err     = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (mmu_ready) begin
                    w_finish    = 1'b1;
                    w_fin_rdata = mmu_write_enable ? 32'd0 : mmu_data_out;
                end else if (r_count == c_cnt_last) begin
                    w_finish  = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic w_fin_i;
    logic w_fin_d;
    assign w_fin_i = w_finish & ~w_fin_owner_d;
    assign w_fin_d = w_finish &  w_fin_owner_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ARB_IDLE;
            r_last_d         <= 1'b0;
            r_owner_d        <= 1'b0;
            r_count          <= '0;
            i_done           <= 1'b0;
            i_rdata          <= 32'd0;
            i_err            <= 1'b0;
            d_done           <= 1'b0;
            d_rdata          <= 32'd0;
            d_err            <= 1'b0;
            mmu_write_enable <= 1'b0;
            mmu_read_enable  <= 1'b0;
            mmu_signed_read  <= 1'b0;
            mmu_data_width   <= 2'b00;
            mmu_address      <= 32'd0;
            mmu_data_in      <= 32'd0;
            busy             <= 1'b0;
        end else begin
            // Completion outputs are one-cycle pulses; the non-owner stays 0
            i_done  <= w_fin_i;
            i_err   <= w_fin_i & w_fin_err;
            i_rdata <= w_fin_i ? w_fin_rdata : 32'd0;
            d_done  <= w_fin_d;
            d_err   <= w_fin_d & w_fin_err;
            d_rdata <= w_fin_d ? w_fin_rdata : 32'd0;

            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_last_d  <= w_grant_d;
                        r_owner_d <= w_grant_d;
                        busy      <= 1'b1;
                        if (w_g_misaligned) begin
                            r_state <= ARB_DONE;
                        end else begin
                            // The mmu_* registers hold the latched request
                            // for the whole BUSY phase.
                            r_state          <= ARB_BUSY;
                            r_count          <= '0;
                            mmu_read_enable  <= ~w_g_we;
                            mmu_write_enable <= w_g_we;
                            mmu_signed_read  <= w_g_signed;
                            mmu_data_width   <= w_g_width;
                            mmu_address      <= w_g_addr;
                            mmu_data_in      <= w_g_wdata;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (w_finish) begin
                        r_state          <= ARB_DONE;
                        mmu_read_enable  <= 1'b0;
                        mmu_write_enable <= 1'b0;
                        mmu_signed_read  <= 1'b0;
                        mmu_data_width   <= 2'b00;
                        mmu_address      <= 32'd0;
                        mmu_data_in      <= 32'd0;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ARB_DONE: begin
                    r_state <= ARB_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state          <= ARB_IDLE;
                    busy             <= 1'b0;
                    mmu_read_enable  <= 1'b0;
                    mmu_write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A latency-programmable
//                mmu stub answers accesses; a byte-addressed reference memory
//                and a cycle-count model predict every output of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_we, d_signed;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_width;
    logic        i_done, i_err, d_done, d_err, busy;
    logic [31:0] i_rdata, d_rdata;
    logic        mmu_write_enable, mmu_read_enable, mmu_signed_read;
    logic [1:0]  mmu_data_width;
    logic [31:0] mmu_address, mmu_data_in;
    logic [31:0] mmu_data_out = 32'd0;
    logic        mmu_ready    = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_signed(d_signed), .d_width(d_width),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mmu_write_enable(mmu_write_enable), .mmu_read_enable(mmu_read_enable),
        .mmu_signed_read(mmu_signed_read), .mmu_data_width(mmu_data_width),
        .mmu_address(mmu_address), .mmu_data_in(mmu_data_in),
        .mmu_data_out(mmu_data_out), .mmu_ready(mmu_ready), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // mmu stub: word-organised memory, answers after a per-access latency
    // taken from a queue in issue order. Optional noise on ready/data
    // while no access is outstanding.
    // ------------------------------------------------------------------
    logic [31:0] stub_mem [0:511];
    int          stub_lat_q[$];
    int          stub_n   = 0;
    int          stub_lat = 0;
    bit          stub_noise = 1'b0;

    function automatic logic [31:0] stub_read(input logic [31:0] a, input logic [1:0] w, input logic s);
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        word = stub_mem[a[10:2]];
        b    = word[8*int'(a[1:0]) +: 8];
        h    = word[16*int'(a[1]) +: 16];
        if (w == MMU_WIDTH_BYTE) return s ? {{24{b[7]}}, b} : {24'd0, b};
        if (w == MMU_WIDTH_HALF) return s ? {{16{h[15]}}, h} : {16'd0, h};
        return word;
    endfunction

    always @(posedge clk) begin
        if (mmu_write_enable && mmu_ready) begin
            if (mmu_data_width == MMU_WIDTH_BYTE)
                stub_mem[mmu_address[10:2]][8*int'(mmu_address[1:0]) +: 8] = mmu_data_in[7:0];
            else if (mmu_data_width == MMU_WIDTH_HALF)
                stub_mem[mmu_address[10:2]][16*int'(mmu_address[1]) +: 16] = mmu_data_in[15:0];
            else
                stub_mem[mmu_address[10:2]] = mmu_data_in;
        end
        #2;
        if (mmu_read_enable || mmu_write_enable) begin
            if (stub_n == 0) stub_lat = (stub_lat_q.size() > 0) ? stub_lat_q.pop_front() : 0;
            stub_n++;
            mmu_ready    = (stub_n > stub_lat);
            mmu_data_out = mmu_read_enable ? stub_read(mmu_address, mmu_data_width, mmu_signed_read) : $urandom;
        end else begin
            stub_n       = 0;
            mmu_ready    = stub_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mmu_data_out = stub_noise ? $urandom : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: byte-addressed memory and access outcome rules
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [int];
    bit         m_last_d = 1'b0;

    typedef struct {
        bit          is_d;
        bit          we;
        bit          sgn;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
    } acc_t;

    function automatic logic [7:0] ref_byte(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        return (w == MMU_WIDTH_BYTE) ? 1 : (w == MMU_WIDTH_HALF) ? 2 : 4;
    endfunction

    function automatic bit ref_bad(input logic [1:0] w, input logic [31:0] a);
        if (w == MMU_WIDTH_WORD) return (a % 4) != 0;
        if (w == MMU_WIDTH_HALF) return (a % 2) != 0;
        if (w == MMU_WIDTH_BYTE) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input bit s);
        int          base;
        logic [31:0] v;
        base = int'(a);
        if (w == MMU_WIDTH_BYTE) begin
            v = {24'd0, ref_byte(base)};
            if (s && v[7]) v = v | 32'hFFFF_FF00;
        end else if (w == MMU_WIDTH_HALF) begin
            v = {16'd0, ref_byte(base + 1), ref_byte(base)};
            if (s && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = {ref_byte(base + 3), ref_byte(base + 2), ref_byte(base + 1), ref_byte(base)};
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] data);
        for (int b = 0; b < nbytes(w); b++) ref_mem[int'(a) + b] = data[8*b +: 8];
    endtask

    function automatic acc_t mk_i(input logic [31:0] a, input int lat);
        acc_t x;
        x.is_d = 1'b0; x.we = 1'b0; x.sgn = 1'b0; x.width = MMU_WIDTH_WORD;
        x.addr = a; x.wdata = 32'd0; x.lat = lat;
        return x;
    endfunction

    function automatic acc_t mk_d(input bit we, input bit sgn, input logic [1:0] w,
                                  input logic [31:0] a, input logic [31:0] data, input int lat);
        acc_t x;
        x.is_d = 1'b1; x.we = we; x.sgn = sgn; x.width = w;
        x.addr = a; x.wdata = data; x.lat = lat;
        return x;
    endfunction

    function automatic int rand_lat();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 10)) : int'($urandom_range(0, 3));
    endfunction

    // ------------------------------------------------------------------
    // Issue the given requests at cycle 0 and check every output on every
    // cycle until the arbiter is idle again. Expected timing per access:
    //   rejected -> done at +1; answered after lat -> done at +lat+2;
    //   lat >= T -> timeout, done at +T+1. A tie loser starts the cycle
    //   after the winner's done.
    // ------------------------------------------------------------------
    task automatic run(input bit has_i, input acc_t ai, input bit has_d, input acc_t ad);
        acc_t        q[2];
        int          n, last, cur;
        int          start[2], done[2];
        bit          bad[2], eerr[2];
        logic [31:0] erd[2];
        logic        e_idone, e_ddone, e_ierr, e_derr, e_busy, e_ren, e_wen;
        logic [31:0] e_ird, e_drd;

        if (has_i && has_d) begin
            if (m_last_d) begin q[0] = ai; q[1] = ad; end
            else          begin q[0] = ad; q[1] = ai; end
            n = 2;
        end else begin
            q[0] = has_i ? ai : ad;
            n = 1;
        end

        for (int j = 0; j < n; j++) begin
            bad[j]   = ref_bad(q[j].width, q[j].addr);
            start[j] = (j == 0) ? 0 : done[0] + 1;
            if (bad[j])              done[j] = start[j] + 1;
            else if (q[j].lat >= T)  done[j] = start[j] + T + 1;
            else                     done[j] = start[j] + q[j].lat + 2;
            eerr[j] = bad[j] || (q[j].lat >= T);
            if (eerr[j]) erd[j] = 32'd0;
            else if (q[j].we) begin
                erd[j] = 32'd0;
                ref_store(q[j].addr, q[j].width, q[j].wdata);
            end else erd[j] = ref_load(q[j].addr, q[j].width, q[j].sgn);
            if (!bad[j]) stub_lat_q.push_back(q[j].lat);
            m_last_d = q[j].is_d;
        end

        i_req = has_i; i_addr = ai.addr;
        d_req = has_d; d_we = ad.we; d_signed = ad.sgn; d_width = ad.width;
        d_addr = ad.addr; d_wdata = ad.wdata;

        last = done[n-1] + 1;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            e_idone = 0; e_ddone = 0; e_ierr = 0; e_derr = 0; e_ird = 0; e_drd = 0;
            e_busy = 0; e_ren = 0; e_wen = 0; cur = -1;
            for (int j = 0; j < n; j++) begin
                if (k > start[j] && k <= done[j]) e_busy = 1;
                if (!bad[j] && k > start[j] && k < done[j]) begin
                    cur = j; e_ren = !q[j].we; e_wen = q[j].we;
                end
                if (k == done[j]) begin
                    if (q[j].is_d) begin e_ddone = 1; e_drd = erd[j]; e_derr = eerr[j]; end
                    else           begin e_idone = 1; e_ird = erd[j]; e_ierr = eerr[j]; end
                end
            end
            check($sformatf("i_done@%0d", k),  i_done,  e_idone);
            check($sformatf("i_rdata@%0d", k), i_rdata, e_ird);
            check($sformatf("i_err@%0d", k),   i_err,   e_ierr);
            check($sformatf("d_done@%0d", k),  d_done,  e_ddone);
            check($sformatf("d_rdata@%0d", k), d_rdata, e_drd);
            check($sformatf("d_err@%0d", k),   d_err,   e_derr);
            check($sformatf("busy@%0d", k),    busy,    e_busy);
            check($sformatf("mmu_rd_en@%0d", k), mmu_read_enable,  e_ren);
            check($sformatf("mmu_wr_en@%0d", k), mmu_write_enable, e_wen);
            if (cur >= 0) begin
                check($sformatf("mmu_addr@%0d", k),   mmu_address,     q[cur].addr);
                check($sformatf("mmu_width@%0d", k),  mmu_data_width,  q[cur].width);
                check($sformatf("mmu_signed@%0d", k), mmu_signed_read, q[cur].sgn);
                if (q[cur].we) check($sformatf("mmu_wdata@%0d", k), mmu_data_in, q[cur].wdata);
            end
            // Requester side: drop req after done, scramble latched fields
            // while the access is in flight.
            for (int j = 0; j < n; j++) begin
                if (k == done[j]) begin
                    if (q[j].is_d) d_req = 1'b0; else i_req = 1'b0;
                end else if (k > start[j] && k < done[j]) begin
                    if (q[j].is_d) begin
                        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
                        d_signed = 1'($urandom_range(0, 1)); d_width = 2'($urandom_range(0, 3));
                    end else i_addr = $urandom;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".i_done"},  i_done,  1'b0);
        check({tag, ".i_rdata"}, i_rdata, 32'd0);
        check({tag, ".i_err"},   i_err,   1'b0);
        check({tag, ".d_done"},  d_done,  1'b0);
        check({tag, ".d_rdata"}, d_rdata, 32'd0);
        check({tag, ".d_err"},   d_err,   1'b0);
        check({tag, ".mmu_wr"},  mmu_write_enable, 1'b0);
        check({tag, ".mmu_rd"},  mmu_read_enable,  1'b0);
        check({tag, ".mmu_sgn"}, mmu_signed_read,  1'b0);
        check({tag, ".mmu_w"},   mmu_data_width,   2'b00);
        check({tag, ".mmu_a"},   mmu_address,      32'd0);
        check({tag, ".mmu_di"},  mmu_data_in,      32'd0);
        check({tag, ".busy"},    busy,             1'b0);
    endtask

    initial begin
        acc_t        ai, ad;
        logic [31:0] a;
        logic [1:0]  w;
        int          r;

        for (int i = 0; i < 512; i++) stub_mem[i] = 32'd0;
        stub_mem[0] = 32'h0020_0293;
        ref_mem[0] = 8'h93; ref_mem[1] = 8'h02; ref_mem[2] = 8'h20; ref_mem[3] = 8'h00;

        reset_n = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_signed = 0; d_width = 0;
        d_addr = 0; d_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Instruction fetch from the test ROM
        run(1'b1, mk_i(32'd0, 0), 1'b0, mk_d(0, 0, MMU_WIDTH_WORD, 0, 0, 0));

        // Two ties in a row: D, I, D, I
        run(1'b1, mk_i(32'd4, 1), 1'b1, mk_d(0, 0, MMU_WIDTH_WORD, 32'd0, 0, 0));
        run(1'b1, mk_i(32'd8, 0), 1'b1, mk_d(0, 1, MMU_WIDTH_HALF, 32'd2, 0, 2));

        // Word store then load back
        run(1'b0, mk_i(0, 0), 1'b1, mk_d(1, 0, MMU_WIDTH_WORD, 32'd1024, 32'hBABA_BABA, 1));
        run(1'b0, mk_i(0, 0), 1'b1, mk_d(0, 0, MMU_WIDTH_WORD, 32'd1024, 32'd0, 2));
        run(1'b0, mk_i(0, 0), 1'b1, mk_d(0, 1, MMU_WIDTH_BYTE, 32'd1027, 32'd0, 0));

        // Misaligned word load: rejected at cycle 1, no mmu activity
        run(1'b0, mk_i(0, 0), 1'b1, mk_d(0, 0, MMU_WIDTH_WORD, 32'd1026, 32'd0, 0));

        // mmu never answers: error pulse at cycle T+1
        run(1'b0, mk_i(0, 0), 1'b1, mk_d(0, 0, MMU_WIDTH_WORD, 32'd1024, 32'd0, 20));

        // Reset during BUSY: enables drop at once, no done pulse
        stub_lat_q.push_back(6);
        i_req = 1'b1; i_addr = 32'd8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_before_reset.rd_en", mmu_read_enable, 1'b1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        i_req = 1'b0;
        @(posedge clk); #1;
        check_all_zero("held_reset");
        reset_n  = 1'b1;
        m_last_d = 1'b0;
        run(1'b1, mk_i(32'd0, 1), 1'b0, mk_d(0, 0, MMU_WIDTH_WORD, 0, 0, 0));

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            r          = int'($urandom_range(1, 3));
            stub_noise = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 511) * 4;
            if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
            ai = mk_i(a, rand_lat());
            r  = r;
            case ($urandom_range(0, 15))
                0, 1, 2, 3, 4:     w = MMU_WIDTH_BYTE;
                5, 6, 7, 8, 9:     w = MMU_WIDTH_HALF;
                15:                w = 2'b11;
                default:           w = MMU_WIDTH_WORD;
            endcase
            a = $urandom_range(0, 2044);
            if ($urandom_range(0, 5) != 0) begin
                if (w == MMU_WIDTH_WORD) a = a & ~32'd3;
                if (w == MMU_WIDTH_HALF) a = a & ~32'd1;
            end
            ad = mk_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, a, $urandom, rand_lat());
            run(r[0], ai, r[1], ad);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
